blinky_multi: RTL

Parametrised multi-channel LED driver, successor to the two-LED blinker. It sits behind the PLL wrapper: `clk` is the PLL output and `reset_n` is driven from PLL lock. Each channel takes an asynchronous switch enable and a mode select, and drives one registered LED output. Channels either blink at a fixed half-period or "breathe" through a triangle-ramped PWM duty.

---
 rtl/blinky_pkg.sv | 16 +
 rtl/blinky_channel.sv | 116 +++++++++++
 rtl/blinky_multi.sv | 59 +++++
 3 files changed

// File: rtl/blinky_pkg.sv
// blinky_pkg: shared types, constants and width helper for the blinky_multi LED driver
package blinky_pkg;
   typedef enum logic {
      MODE_BLINK   = 1'b0,
      MODE_BREATHE = 1'b1
   } mode_e;
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_e;
   localparam int SYNC_STAGES = 2;
   // Counter width able to hold 0..v-1, never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction
endpackage

// File: rtl/blinky_channel.sv
// blinky_channel: one LED channel -- optional en debounce, IDLE/RUN FSM, blink and breathe datapaths, led flop
//   Debounce is built only when BLINKY_DEBOUNCE_EN is defined.
//   Ports: clk_i clock, rst_ni async active-low reset, tick_i prescaler tick,
//          en_i synchronised enable, mode_i synchronised mode, pwm_i shared PWM count,
//          led_o registered LED drive (1 = lit).
module blinky_channel
   import blinky_pkg::*;
#(
   parameter int PERIOD_TICKS   = 500,
   parameter int PWM_BITS       = 8,
   parameter int DEBOUNCE_TICKS = 20,
   parameter bit INVERT         = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                tick_i,
   input  logic                en_i,
   input  mode_e               mode_i,
   input  logic [PWM_BITS-1:0] pwm_i,
   output logic                led_o
);
   localparam int PH_W = clog2_min1(PERIOD_TICKS);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD_TICKS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   logic en_acc;
   chan_state_e state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic blink_q, blink_d;
   logic dir_dn_q, dir_dn_d;
   logic led_q, led_d;
   logic start, step;
`ifdef BLINKY_DEBOUNCE_EN
   localparam int DB_W = clog2_min1(DEBOUNCE_TICKS + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic acc_q, acc_d;
   // Count ticks during which the input disagrees with the accepted level;
   // any return to agreement discards the partial count.
   always_comb begin
      acc_d = acc_q;
      db_cnt_d = db_cnt_q;
      if (en_i == acc_q)
         db_cnt_d = '0;
      else if (tick_i) begin
         acc_d = (db_cnt_q == DB_LAST) ? en_i : acc_q;
         db_cnt_d = (db_cnt_q == DB_LAST) ? '0 : db_cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         db_cnt_q <= db_cnt_d;
      end
   end
   assign en_acc = acc_q;
`else
   assign en_acc = en_i;
`endif
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end
   always_comb begin
      state_d = en_acc ? ST_RUN : ST_IDLE;
   end
   always_comb begin
      led_d = (state_q == ST_RUN) &&
              ((mode_i == MODE_BREATHE) ? (pwm_i < duty_q) : (blink_q ^ INVERT));
   end
   // Entry restarts the pattern; a tick in the entry cycle or in the
   // disable cycle is deliberately dropped.
   assign start = (state_q == ST_IDLE) && en_acc;
   assign step  = (state_q == ST_RUN) && en_acc && tick_i;
   always_comb begin
      phase_d = phase_q;
      blink_d = blink_q;
      duty_d = duty_q;
      dir_dn_d = dir_dn_q;
      if (start) begin
         phase_d = '0;
         blink_d = 1'b1;
         duty_d = '0;
         dir_dn_d = 1'b0;
      end else if (step && mode_i == MODE_BLINK) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
         blink_d = blink_q ^ (phase_q == PH_LAST);
      end else if (step) begin
         // The turn-around tick at either end only flips direction.
         dir_dn_d = dir_dn_q ? (duty_q != '0) : (duty_q == DUTY_MAX);
         duty_d = dir_dn_q ? ((duty_q == '0) ? duty_q : duty_q - 1'b1)
                           : ((duty_q == DUTY_MAX) ? duty_q : duty_q + 1'b1);
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= '0;
         blink_q <= 1'b0;
         duty_q <= '0;
         dir_dn_q <= 1'b0;
         led_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         blink_q <= blink_d;
         duty_q <= duty_d;
         dir_dn_q <= dir_dn_d;
         led_q <= led_d;
      end
   end
   assign led_o = led_q;
endmodule

// File: rtl/blinky_multi.sv
// blinky_multi: multi-channel LED driver, each channel blinking or breathing (triangle PWM)
//   Defining BLINKY_DEBOUNCE_EN adds per-channel debounce of en.
//   Ports: clk PLL clock, reset_n async active-low reset (PLL lock),
//          en/mode per-channel asynchronous enable and mode (0 blink, 1 breathe),
//          led registered per-channel drive, tick one-clk pulse per prescaler wrap.
module blinky_multi
   import blinky_pkg::*;
#(
   parameter int CHANNELS       = 2,
   parameter int PRESCALE       = 48000,
   parameter int PERIOD_TICKS   = 500,
   parameter int PWM_BITS       = 8,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] mode,
   output logic [CHANNELS-1:0] led,
   output logic                tick
);
   localparam int PRE_W = clog2_min1(PRESCALE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] en_sync_q, mode_sync_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + 1'b1;
   assign pwm_d = pwm_q + 1'b1;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_sync_q <= '0;
         mode_sync_q <= '0;
         pre_q <= '0;
         pwm_q <= '0;
      end else begin
         en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], en};
         mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], mode};
         pre_q <= pre_d;
         pwm_q <= pwm_d;
      end
   end
   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      blinky_channel #(
         .PERIOD_TICKS  (PERIOD_TICKS),
         .PWM_BITS      (PWM_BITS),
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
         .INVERT        (c % 2 == 1)
      ) u_chan (
         .clk_i (clk),
         .rst_ni(reset_n),
         .tick_i(tick),
         .en_i  (en_sync_q[SYNC_STAGES-1][c]),
         .mode_i(mode_e'(mode_sync_q[SYNC_STAGES-1][c])),
         .pwm_i (pwm_q),
         .led_o (led[c])
      );
   end
endmodule
